// File: rtl/k12_pkg.sv
// Shared types and constants for the K12 instruction sequencer.
package k12_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned INST_W = 16;
    localparam int unsigned RF_AW  = 3;

    // Instruction field positions
    localparam int unsigned CLS_HI  = 15;
    localparam int unsigned CLS_LO  = 14;
    localparam int unsigned SYS_BIT = 13;
    localparam int unsigned OFS_HI  = 7;
    localparam int unsigned OFS_LO  = 0;
    localparam int unsigned REG_HI  = 2;
    localparam int unsigned REG_LO  = 0;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_CMP = 2'b01;
    localparam logic [1:0] CLS_JMP = 2'b10;
    localparam logic [1:0] CLS_SYS = 2'b11;

    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        EXEC     = 2'd2,
        HALT     = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]  cls;
        logic [13:0] body;
    } inst_t;

    // Signed word offset of a relative jump, expressed in bytes.
    function automatic logic [ADDR_W-1:0] jump_ofs(input logic [DATA_W-1:0] ofs8);
        return {{(ADDR_W-DATA_W-1){ofs8[DATA_W-1]}}, ofs8, 1'b0};
    endfunction

endpackage

// File: rtl/k12_seq_pcnext.sv
// Combinational next-pc selection for the EXEC cycle plus the low-byte fetch address.
module k12_seq_pcnext
    import k12_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        cls,
    input  logic [DATA_W-1:0] ofs8,
    input  logic              alu_cond,
    output logic [ADDR_W-1:0] pc_lo_c,
    output logic [ADDR_W-1:0] npc_c
);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] skip_pc;

    // All sums wrap naturally at ADDR_W bits.
    assign pc_lo_c = pc + ADDR_W'(1);
    assign seq_pc  = pc + ADDR_W'(2);
    assign skip_pc = pc + ADDR_W'(4);

    always_comb begin
        npc_c = seq_pc;
        unique case (cls)
            CLS_CMP: npc_c = alu_cond ? skip_pc : seq_pc;
            CLS_JMP: npc_c = seq_pc + jump_ofs(ofs8);
            default: npc_c = seq_pc;
        endcase
    end

endmodule

// File: rtl/k12_seq.sv
// K12 multi-cycle sequencer: two-byte fetch, single-cycle execute, accumulator and
// register-file write-back.
module k12_seq
    import k12_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [RF_AW-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [INST_W-1:0] alu_inst,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_cond,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d;
    inst_t             ir_q, ir_d;
    logic [ADDR_W-1:0] pc_lo_c;
    logic [ADDR_W-1:0] npc_c;

    k12_seq_pcnext u_pcnext (
        .pc       (pc_q),
        .cls      (ir_q.cls),
        .ofs8     (ir_q[OFS_HI:OFS_LO]),
        .alu_cond (alu_cond),
        .pc_lo_c  (pc_lo_c),
        .npc_c    (npc_c)
    );

    // State and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_HI;
            pc_q    <= RESET_PC;
            a_q     <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and strobe decode; reset masks every strobe in its own cycle.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        a_d      = a_q;
        ir_d     = ir_q;
        mem_req  = 1'b0;
        mem_addr = pc_q;
        rf_we    = 1'b0;
        halted   = 1'b0;

        unique case (state_q)
            FETCH_HI: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_d[INST_W-1:DATA_W] = mem_rdata;
                    state_d               = FETCH_LO;
                end
            end
            FETCH_LO: begin
                mem_req  = 1'b1;
                mem_addr = pc_lo_c;
                if (mem_ack) begin
                    ir_d[DATA_W-1:0] = mem_rdata;
                    state_d          = EXEC;
                end
            end
            EXEC: begin
                pc_d    = npc_c;
                state_d = FETCH_HI;
                if (ir_q.cls == CLS_ALU) begin
                    a_d = alu_res;
                end else if (ir_q.cls == CLS_SYS) begin
                    if (ir_q[SYS_BIT]) begin
                        rf_we = 1'b1;
                    end else begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = FETCH_HI;
            end
        endcase

        if (reset) begin
            mem_req = 1'b0;
            rf_we   = 1'b0;
            halted  = 1'b0;
        end
    end

    assign rf_raddr = ir_q[REG_HI:REG_LO];
    assign rf_waddr = ir_q[REG_HI:REG_LO];
    assign rf_wdata = a_q;
    assign alu_a    = a_q;
    assign alu_b    = rf_rdata;
    assign alu_inst = ir_q;
    assign pc       = pc_q;

endmodule
